tb_smu_322: RTL

Survivor-memory and traceback stage for the (3,2,2) backward-label Viterbi decoder. It sits directly downstream of the four ACS blocks.
- Each accepted decoding step, it stores the four k-bit survivor decisions (Bx) in a circular register file.
- It selects the minimum-metric state from the four path metrics (ppm) and traces back L steps.
- It emits the k decoded information bits for the step L positions older than the newest entry.

---
 rtl/tb_smu_322.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tb_smu_322.sv
// Survivor memory and traceback for the (3,2,2) Viterbi decoder: stores per-step
// ACS decisions, traces back L steps from the best state, emits k decoded bits.
module tb_smu_322 #(
  parameter int W  = 4,
  parameter int k  = 2,
  parameter int S  = 4,
  parameter int AW = 4,
  parameter int L  = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dec_valid,
  input  logic [k-1:0] dec0,
  input  logic [k-1:0] dec1,
  input  logic [k-1:0] dec2,
  input  logic [k-1:0] dec3,
  input  logic [W-1:0] ppm0,
  input  logic [W-1:0] ppm1,
  input  logic [W-1:0] ppm2,
  input  logic [W-1:0] ppm3,
  output logic [k-1:0] out_bits,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FILL_MAX  = (AW+1)'(L + 1);
  localparam logic [AW-1:0] LAST_STEP = AW'(L - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW:0]     fill_inc;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [AW-1:0]   step_q, step_d;
  logic [k-1:0]    cur_q, cur_d;
  logic [k-1:0]    out_bits_q, out_bits_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            trigger;

  logic [S*k-1:0]  mem [DEPTH];
  logic [S*k-1:0]  wdata;
  logic [S*k-1:0]  rd_word;
  logic [W-1:0]    ppm_a [S];
  logic [W-1:0]    best_val;
  logic [k-1:0]    best_idx;

  assign wdata    = {dec3, dec2, dec1, dec0};
  assign ppm_a[0] = ppm0;
  assign ppm_a[1] = ppm1;
  assign ppm_a[2] = ppm2;
  assign ppm_a[3] = ppm3;

  // Survivor register file: no reset, written on every accepted step
  // regardless of the traceback state.
  always_ff @(posedge clock) begin
    if (dec_valid) begin
      mem[wptr_q] <= wdata;
    end
  end

  assign rd_word = mem[raddr_q];

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = ppm_a[0];
    for (int s = 1; s < S; s++) begin
      if (ppm_a[s] < best_val) begin
        best_val = ppm_a[s];
        best_idx = k'(s);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    raddr_d     = raddr_q;
    step_d      = step_q;
    cur_d       = cur_q;
    out_bits_d  = out_bits_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    trigger  = dec_valid && (state_q == IDLE) && (fill_inc == FILL_MAX);

    if (dec_valid) begin
      wptr_d = wptr_q + 1'b1;
      fill_d = fill_inc;
      if (busy_q || (state_q == EMIT)) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = TRACE;
          cur_d   = best_idx;
          raddr_d = wptr_q;
          step_d  = '0;
          busy_d  = 1'b1;
        end
      end
      TRACE: begin
        // The decision stored for the current state is its predecessor.
        cur_d   = rd_word[int'(cur_q)*k +: k];
        raddr_d = raddr_q - 1'b1;
        step_d  = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_bits_d  = cur_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      fill_q      <= '0;
      raddr_q     <= '0;
      step_q      <= '0;
      cur_q       <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      raddr_q     <= raddr_d;
      step_q      <= step_d;
      cur_q       <= cur_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_bits  = out_bits_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
